// File: rtl/block_fetch_ctrl.sv
// Fetches a frame from the get3 pixel source in 8x8 block order, converts each pixel to luma,
// buffers one block and streams it to the DCT input over a valid/ready handshake.
module block_fetch_ctrl #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        pix_req,
    output logic [10:0] pix_req_x,
    output logic [10:0] pix_req_y,
    input  logic        pix_valid,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic [7:0]  blk_data,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic        blk_last,
    output logic        err_coord,
    output logic        err_timeout
);

    localparam logic [7:0]  LAST_BC   = 8'(IMG_W / 8 - 1);
    localparam logic [7:0]  LAST_BR   = 8'(IMG_H / 8 - 1);
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t      state_reg;
    logic [7:0]  bc_reg;
    logic [7:0]  br_reg;
    logic [5:0]  idx_reg;
    logic [5:0]  k_reg;
    logic [15:0] wait_cnt_reg;

    logic [7:0]  buf_mem [0:63];

    logic [15:0] luma_sum;
    logic [7:0]  luma;
    logic        take_sample;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        coord_bad;
    logic [5:0]  idx_next;
    logic [5:0]  k_next;
    logic        last_bc;
    logic        last_blk;
    logic [7:0]  bc_next;
    logic [7:0]  br_next;

    always_comb begin
        luma_sum    = 16'd77 * {8'd0, pix_r} + 16'd150 * {8'd0, pix_g}
                    + 16'd29 * {8'd0, pix_b} + 16'd128;
        luma        = 8'(luma_sum >> 8);
        // A timed-out pixel advances exactly like a returned one, but stores 0.
        take_sample = pix_valid || (wait_cnt_reg == LAST_WAIT);
        wr_en       = (state_reg == S_WAIT) && take_sample;
        wr_data     = pix_valid ? luma : 8'd0;
        coord_bad   = (pix_x != pix_req_x) || (pix_y != pix_req_y);
        idx_next    = idx_reg + 6'd1;
        k_next      = k_reg + 6'd1;
        last_bc     = (bc_reg == LAST_BC);
        last_blk    = last_bc && (br_reg == LAST_BR);
        bc_next     = last_bc ? 8'd0 : bc_reg + 8'd1;
        br_next     = last_bc ? br_reg + 8'd1 : br_reg;
    end

    always_ff @(posedge clk_clk) begin
        if (wr_en) begin
            buf_mem[idx_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg    <= S_IDLE;
            bc_reg       <= 8'd0;
            br_reg       <= 8'd0;
            idx_reg      <= 6'd0;
            k_reg        <= 6'd0;
            wait_cnt_reg <= 16'd0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            pix_req      <= 1'b0;
            pix_req_x    <= 11'd0;
            pix_req_y    <= 11'd0;
            blk_data     <= 8'd0;
            blk_valid    <= 1'b0;
            blk_last     <= 1'b0;
            err_coord    <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            pix_req    <= 1'b0;
            frame_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        bc_reg      <= 8'd0;
                        br_reg      <= 8'd0;
                        idx_reg     <= 6'd0;
                        err_coord   <= 1'b0;
                        err_timeout <= 1'b0;
                        pix_req     <= 1'b1;
                        pix_req_x   <= 11'd0;
                        pix_req_y   <= 11'd0;
                        state_reg   <= S_REQ;
                    end
                end
                S_REQ: begin
                    wait_cnt_reg <= 16'd0;
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    if (take_sample) begin
                        if (pix_valid && coord_bad) begin
                            err_coord <= 1'b1;
                        end
                        if (!pix_valid) begin
                            err_timeout <= 1'b1;
                        end
                        if (idx_reg == 6'd63) begin
                            // Slot 63 is being written this cycle; slot 0 is long settled.
                            k_reg     <= 6'd0;
                            blk_data  <= buf_mem[0];
                            blk_valid <= 1'b1;
                            blk_last  <= 1'b0;
                            state_reg <= S_DRAIN;
                        end else begin
                            idx_reg   <= idx_next;
                            pix_req   <= 1'b1;
                            pix_req_x <= {bc_reg, idx_next[2:0]};
                            pix_req_y <= {br_reg, idx_next[5:3]};
                            state_reg <= S_REQ;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (blk_ready) begin
                        if (k_reg == 6'd63) begin
                            blk_valid <= 1'b0;
                            blk_last  <= 1'b0;
                            idx_reg   <= 6'd0;
                            if (last_blk) begin
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                                state_reg  <= S_IDLE;
                            end else begin
                                bc_reg    <= bc_next;
                                br_reg    <= br_next;
                                pix_req   <= 1'b1;
                                pix_req_x <= {bc_next, 3'd0};
                                pix_req_y <= {br_next, 3'd0};
                                state_reg <= S_REQ;
                            end
                        end else begin
                            k_reg    <= k_next;
                            blk_data <= buf_mem[k_next];
                            blk_last <= (k_next == 6'd63);
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_fetch_ctrl.sv
// Directed bench for block_fetch_ctrl on a 16x8 frame (two blocks) with a short wait timeout.
module tb_block_fetch_ctrl;

    localparam int IMG_W   = 16;
    localparam int IMG_H   = 8;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic        blk_ready = 1'b1;
    logic [10:0] pix_x = 11'd0;
    logic [10:0] pix_y = 11'd0;
    logic [7:0]  pix_r = 8'd0;
    logic [7:0]  pix_g = 8'd0;
    logic [7:0]  pix_b = 8'd0;
    logic        busy, frame_done, pix_req, blk_valid, blk_last, err_coord, err_timeout;
    logic [10:0] pix_req_x, pix_req_y;
    logic [7:0]  blk_data;

    block_fetch_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .TIMEOUT(TIMEOUT)) dut (
        .clk_clk(clk), .reset_reset(rst), .start(start), .busy(busy),
        .frame_done(frame_done), .pix_req(pix_req), .pix_req_x(pix_req_x),
        .pix_req_y(pix_req_y), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .blk_data(blk_data),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_last(blk_last),
        .err_coord(err_coord), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Source model and DCT-side monitor
    int          resp_cnt = 0, req_n = 0, silent_idx = -1, bad_idx = -1;
    int          rdy_mode = 0, cyc = 0, done_cnt = 0, blkno = 0;
    logic [10:0] cur_x = 11'd0, cur_y = 11'd0;
    logic [7:0]  col_r [2], col_g [2], col_b [2];
    int          req_x_q[$], req_y_q[$], smp_q[$], last_q[$];

    always @(negedge clk) begin
        cyc++;
        pix_valid = 1'b0;
        if (rst) begin
            resp_cnt = 0;
        end else begin
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    blkno     = ((req_n - 1) / 64) & 1;
                    pix_valid = 1'b1;
                    pix_x     = ((req_n - 1) == bad_idx) ? (cur_x ^ 11'd1) : cur_x;
                    pix_y     = cur_y;
                    pix_r     = col_r[blkno];
                    pix_g     = col_g[blkno];
                    pix_b     = col_b[blkno];
                end
            end
            if (pix_req) begin
                req_x_q.push_back(int'(pix_req_x));
                req_y_q.push_back(int'(pix_req_y));
                cur_x = pix_req_x;
                cur_y = pix_req_y;
                if (req_n != silent_idx) resp_cnt = 2;
                req_n++;
            end
        end
        blk_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        if (blk_valid && blk_ready) begin
            smp_q.push_back(int'(blk_data));
            last_q.push_back(int'(blk_last));
        end
        if (frame_done) done_cnt++;
    end

    task automatic setup(input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
                         input logic [7:0] r1, input logic [7:0] g1, input logic [7:0] b1,
                         input int rmode, input int sil, input int bad);
        col_r[0] = r0; col_g[0] = g0; col_b[0] = b0;
        col_r[1] = r1; col_g[1] = g1; col_b[1] = b1;
        rdy_mode = rmode; silent_idx = sil; bad_idx = bad;
    endtask

    task automatic kick_frame();
        req_x_q.delete(); req_y_q.delete(); smp_q.delete(); last_q.delete();
        req_n = 0; done_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("first_req", int'(pix_req), 1);
        chk("first_req_xy", int'({pix_req_x, pix_req_y}), 0);
        chk("err_cleared", int'({err_coord, err_timeout}), 0);
    endtask

    task automatic wait_done(input int extra_start);
        for (int i = 0; i < 5000 && done_cnt == 0; i++) begin
            @(posedge clk);
            #1;
            start = (extra_start != 0 && i == 100);
        end
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("frame_done_pulses", done_cnt, 1);
        chk("busy_after_done", int'(busy), 0);
    endtask

    task automatic verify_frame(input int exp0, input int exp1, input int zero_idx,
                                input int e_coord, input int e_to);
        int bad_ord, bad_val, bad_last, ex;
        bad_ord = 0; bad_val = 0; bad_last = 0;
        chk("n_requests", req_x_q.size(), 128);
        chk("n_samples", smp_q.size(), 128);
        if (req_x_q.size() == 128) begin
            for (int i = 0; i < 128; i++) begin
                if (req_x_q[i] != (i / 64) * 8 + (i % 8) || req_y_q[i] != (i % 64) / 8) bad_ord++;
            end
        end
        if (smp_q.size() == 128) begin
            for (int i = 0; i < 128; i++) begin
                ex = (i == zero_idx) ? 0 : ((i < 64) ? exp0 : exp1);
                if (smp_q[i] != ex) bad_val++;
                if (last_q[i] != ((i % 64) == 63 ? 1 : 0)) bad_last++;
            end
        end
        chk("req_order_errors", bad_ord, 0);
        chk("sample_value_errors", bad_val, 0);
        chk("blk_last_errors", bad_last, 0);
        chk("err_coord", int'(err_coord), e_coord);
        chk("err_timeout", int'(err_timeout), e_to);
        $display("frame: %0d requests, %0d samples, err_coord=%0d err_timeout=%0d",
                 req_x_q.size(), smp_q.size(), err_coord, err_timeout);
    endtask

    initial begin
        setup(8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 0, -1, -1);
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pix_req", int'(pix_req), 0);
        chk("rst_blk_valid", int'(blk_valid), 0);
        chk("rst_err", int'({err_coord, err_timeout}), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Grey 200 everywhere, ready always high
        kick_frame();
        wait_done(0);
        verify_frame(200, 200, -1, 0, 0);

        // Pure red block then pure blue block
        setup(8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 0, -1, -1);
        kick_frame();
        wait_done(0);
        verify_frame(77, 29, -1, 0, 0);

        // White, sparse ready, silent pixel 5, bad echo on pixel 10, stray start mid-frame
        setup(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1, 5, 10);
        kick_frame();
        wait_done(1);
        verify_frame(255, 255, 5, 1, 1);

        // Reset in the middle of draining block (0,0)
        setup(8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 0, -1, -1);
        kick_frame();
        for (int i = 0; i < 3000 && smp_q.size() < 30; i++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_k30", smp_q.size(), 30);
        rst = 1'b1;
        #1;
        chk("midrst_blk_valid", int'(blk_valid), 0);
        chk("midrst_blk_data", int'(blk_data), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pix_req", int'(pix_req), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        kick_frame();
        wait_done(0);
        verify_frame(200, 200, -1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
